// File: rtl/noc_local_endpoint.sv
// noc_local_endpoint
// Network interface between a processing element and a router's local (L) port.
// TX: packs host requests into 16-bit flits {payload, dest_x, dest_y} and sends
//     them to the router under credit-based flow control.
// RX: buffers flits from the router in a small circular FIFO and returns one
//     credit to the router for every flit the host pops.

module noc_local_endpoint #(
    parameter int XCOORD     = 0,
    parameter int YCOORD     = 0,
    parameter int TX_CREDITS = 4,
    parameter int RX_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [3:0]  tx_dest_x,
    input  logic [3:0]  tx_dest_y,
    input  logic [7:0]  tx_payload,
    output logic [15:0] net_data_o,
    output logic        net_enable_o,
    input  logic        net_credit_i,
    input  logic [15:0] net_data_i,
    input  logic        net_enable_i,
    output logic        net_credit_o,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [15:0] rx_data,
    output logic [3:0]  my_x,
    output logic [3:0]  my_y,
    output logic        credit_err,
    output logic        rx_overflow
);

    localparam int CW = $clog2(TX_CREDITS + 1);
    localparam int PW = $clog2(RX_DEPTH);
    localparam int OW = $clog2(RX_DEPTH + 1);

    localparam logic [CW-1:0] LP_CRED_MAX = CW'(TX_CREDITS);
    localparam logic [OW-1:0] LP_RX_FULL  = OW'(RX_DEPTH);
    localparam logic [3:0]    LP_MY_X     = 4'(XCOORD);
    localparam logic [3:0]    LP_MY_Y     = 4'(YCOORD);

    // TX state
    logic [CW-1:0] r_credit_cnt;
    logic          r_credit_err;
    logic [15:0]   r_net_data;
    logic          r_net_enable;

    // RX state
    logic [15:0]   r_mem [RX_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [OW-1:0] r_count;
    logic          r_rx_overflow;
    logic          r_net_credit;

    // Combinational control
    logic          w_send;
    logic [CW-1:0] w_credit_next;
    logic          w_credit_err_set;
    logic          w_rx_nonempty;
    logic          w_rx_full;
    logic          w_pop;
    logic          w_wr_accept;
    logic          w_overflow_set;
    logic [OW-1:0] w_count_next;

    // tx_ready comes straight from the credit register so it never depends on tx_valid
    assign tx_ready      = (r_credit_cnt != '0);
    assign w_send        = tx_valid && tx_ready;

    assign w_rx_nonempty = (r_count != '0);
    assign w_rx_full     = (r_count == LP_RX_FULL);
    assign w_pop         = w_rx_nonempty && rx_ready;
    // A pop in the same cycle frees the slot the incoming flit needs
    assign w_wr_accept    = net_enable_i && (!w_rx_full || w_pop);
    assign w_overflow_set = net_enable_i && w_rx_full && !w_pop;

    assign net_data_o   = r_net_data;
    assign net_enable_o = r_net_enable;
    assign net_credit_o = r_net_credit;
    assign rx_valid     = w_rx_nonempty;
    assign rx_data      = w_rx_nonempty ? r_mem[r_rd_ptr] : 16'h0000;
    assign my_x         = LP_MY_X;
    assign my_y         = LP_MY_Y;
    assign credit_err   = r_credit_err;
    assign rx_overflow  = r_rx_overflow;

    // Next TX credit count; a credit at full count saturates and flags an error
    always_comb begin
        w_credit_next    = r_credit_cnt;
        w_credit_err_set = 1'b0;
        if (w_send && net_credit_i) begin
            w_credit_next = r_credit_cnt;
        end else if (w_send) begin
            w_credit_next = r_credit_cnt - CW'(1);
        end else if (net_credit_i) begin
            if (r_credit_cnt == LP_CRED_MAX) begin
                w_credit_err_set = 1'b1;
            end else begin
                w_credit_next = r_credit_cnt + CW'(1);
            end
        end else begin
            w_credit_next = r_credit_cnt;
        end
    end

    // Next RX occupancy from accepted write / pop combination
    always_comb begin
        w_count_next = r_count;
        case ({w_wr_accept, w_pop})
            2'b10:   w_count_next = r_count + OW'(1);
            2'b01:   w_count_next = r_count - OW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // TX credit counter, sticky credit error and the registered flit output
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_credit_cnt <= LP_CRED_MAX;
            r_credit_err <= 1'b0;
            r_net_data   <= 16'h0000;
            r_net_enable <= 1'b0;
        end else begin
            r_credit_cnt <= w_credit_next;
            r_credit_err <= r_credit_err | w_credit_err_set;
            r_net_enable <= w_send;
            if (w_send) begin
                r_net_data <= {tx_payload, tx_dest_x, tx_dest_y};
            end
        end
    end

    // RX pointers, occupancy, sticky overflow flag and the per-pop credit pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_rx_overflow <= 1'b0;
            r_net_credit  <= 1'b0;
        end else begin
            r_count       <= w_count_next;
            r_rx_overflow <= r_rx_overflow | w_overflow_set;
            r_net_credit  <= w_pop;
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // RX storage; cleared on reset so rx_data never carries stale contents
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < RX_DEPTH; i++) begin
                r_mem[i] <= 16'h0000;
            end
        end else if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= net_data_i;
        end
    end

endmodule

// File: tb/tb_noc_local_endpoint.sv
// Directed self-checking bench for noc_local_endpoint.
module tb_noc_local_endpoint;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  tx_dest_x;
    logic [3:0]  tx_dest_y;
    logic [7:0]  tx_payload;
    logic [15:0] net_data_o;
    logic        net_enable_o;
    logic        net_credit_i;
    logic [15:0] net_data_i;
    logic        net_enable_i;
    logic        net_credit_o;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] rx_data;
    logic [3:0]  my_x;
    logic [3:0]  my_y;
    logic        credit_err;
    logic        rx_overflow;

    int n_checks = 0;
    int n_errors = 0;

    noc_local_endpoint #(
        .XCOORD(5), .YCOORD(9), .TX_CREDITS(4), .RX_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y), .tx_payload(tx_payload),
        .net_data_o(net_data_o), .net_enable_o(net_enable_o),
        .net_credit_i(net_credit_i),
        .net_data_i(net_data_i), .net_enable_i(net_enable_i),
        .net_credit_o(net_credit_o),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .my_x(my_x), .my_y(my_y),
        .credit_err(credit_err), .rx_overflow(rx_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic credit_pulse();
        net_credit_i = 1'b1;
        step();
        net_credit_i = 1'b0;
    endtask

    initial begin
        int k;
        logic [15:0] exp_d;
        logic        acc;

        rst = 1'b0; tx_valid = 1'b0; tx_dest_x = 4'd0; tx_dest_y = 4'd0;
        tx_payload = 8'h00; net_credit_i = 1'b0; net_data_i = 16'h0000;
        net_enable_i = 1'b0; rx_ready = 1'b0;

        // ---------------- reset ----------------
        step(); step();
        rst = 1'b1;
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 16'h0000);
        chk("rst_net_en", net_enable_o, 0);
        chk("rst_net_data", net_data_o, 16'h0000);
        chk("rst_net_credit", net_credit_o, 0);
        chk("rst_credit_err", credit_err, 0);
        chk("rst_overflow", rx_overflow, 0);
        chk("my_x", my_x, 4'd5);
        chk("my_y", my_y, 4'd9);

        // ---------------- credit exhaustion ----------------
        tx_dest_x = 4'd2; tx_dest_y = 4'd3; tx_valid = 1'b1;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            tx_payload = 8'hA0 + 8'(k);
            chk("exh_ready", tx_ready, (k < 4) ? 1 : 0);
            acc = (k < 4);
            exp_d = {8'hA0 + 8'(k), 8'h23};
            step();
            chk("exh_en", net_enable_o, acc);
            if (acc) begin
                chk("exh_data", net_data_o, exp_d);
                k++;
            end
        end
        chk("exh_hold_data", net_data_o, 16'hA323);
        chk("exh_not_ready", tx_ready, 0);
        tx_valid = 1'b0;
        credit_pulse();
        chk("cred_ready", tx_ready, 1);
        tx_valid = 1'b1; tx_payload = 8'hA4;
        step();
        tx_valid = 1'b0;
        chk("a4_en", net_enable_o, 1);
        chk("a4_data", net_data_o, 16'hA423);
        chk("a4_empty", tx_ready, 0);
        step();
        chk("idle_en", net_enable_o, 0);
        chk("idle_hold", net_data_o, 16'hA423);

        // ---------------- send + credit at count=1 ----------------
        credit_pulse();
        tx_valid = 1'b1; tx_payload = 8'hB0; net_credit_i = 1'b1;
        step();
        tx_valid = 1'b0; net_credit_i = 1'b0;
        chk("sc_en", net_enable_o, 1);
        chk("sc_data", net_data_o, 16'hB023);
        chk("sc_ready", tx_ready, 1);
        // count 1 -> 4, then one extra credit
        credit_pulse(); credit_pulse(); credit_pulse();
        chk("c4_err", credit_err, 0);
        credit_pulse();
        chk("extra_err", credit_err, 1);
        // count must still be exactly 4: four sends then not ready
        tx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_payload = 8'hD0 + 8'(i);
            exp_d = {8'hD0 + 8'(i), 8'h23};
            step();
            chk("sat_en", net_enable_o, 1);
            chk("sat_data", net_data_o, exp_d);
        end
        tx_valid = 1'b0;
        chk("sat_empty", tx_ready, 0);
        credit_pulse(); // count = 1 for the reset test
        chk("err_sticky", credit_err, 1);

        // ---------------- RX fill + overflow ----------------
        rx_ready = 1'b0; net_enable_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            net_data_i = 16'h1100 + 16'(i);
            step();
            chk("fill_valid", rx_valid, 1);
            chk("fill_head", rx_data, 16'h1100);
            chk("fill_no_credit", net_credit_o, 0);
        end
        net_data_i = 16'h1104;
        step();
        net_enable_i = 1'b0;
        chk("ovf_flag", rx_overflow, 1);
        chk("ovf_head", rx_data, 16'h1100);

        // ---------------- RX drain ----------------
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", rx_valid, 1);
            chk("drain_data", rx_data, 16'h1100 + 16'(i));
            step();
            chk("drain_credit", net_credit_o, 1);
        end
        chk("drain_empty", rx_valid, 0);
        step();
        chk("drain_credit_end", net_credit_o, 0);
        rx_ready = 1'b0;

        // ---------------- reset mid-operation ----------------
        net_enable_i = 1'b1;
        net_data_i = 16'h2200; step();
        net_data_i = 16'h2201; step();
        net_enable_i = 1'b0;
        chk("mid_valid", rx_valid, 1);
        chk("mid_ready_c1", tx_ready, 1);
        rst = 1'b0; rx_ready = 1'b1; tx_valid = 1'b1; tx_payload = 8'hC0;
        step();
        chk("mr_tx_ready", tx_ready, 1);
        chk("mr_rx_valid", rx_valid, 0);
        chk("mr_rx_data", rx_data, 16'h0000);
        chk("mr_net_en", net_enable_o, 0);
        chk("mr_net_data", net_data_o, 16'h0000);
        chk("mr_net_credit", net_credit_o, 0);
        chk("mr_credit_err", credit_err, 0);
        chk("mr_overflow", rx_overflow, 0);
        tx_valid = 1'b0;
        step();
        chk("mr_net_credit2", net_credit_o, 0);
        rst = 1'b1; rx_ready = 1'b0;
        step();
        chk("mr_post_credit", net_credit_o, 0);
        chk("mr_post_valid", rx_valid, 0);

        // ---------------- simultaneous write + pop while full ----------------
        net_enable_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            net_data_i = 16'h3300 + 16'(i);
            step();
        end
        net_data_i = 16'h3304; rx_ready = 1'b1;
        chk("wp_head", rx_data, 16'h3300);
        step();
        net_enable_i = 1'b0;
        chk("wp_no_ovf", rx_overflow, 0);
        chk("wp_credit", net_credit_o, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("wp_valid", rx_valid, 1);
            chk("wp_order", rx_data, 16'h3300 + 16'(i));
            step();
        end
        rx_ready = 1'b0;
        chk("wp_empty", rx_valid, 0);
        chk("wp_no_ovf_end", rx_overflow, 0);

        // ---------------- self-addressed flit ----------------
        tx_valid = 1'b1; tx_dest_x = 4'd5; tx_dest_y = 4'd9; tx_payload = 8'h5A;
        step();
        tx_valid = 1'b0;
        chk("self_en", net_enable_o, 1);
        chk("self_data", net_data_o, 16'h5A59);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
